// File: rtl/mem_readout_if.sv
`default_nettype none
// ============================================================================
// mem_readout_if : output-RAM read port plus valid/ready byte stream
// Revision 1.0
// ============================================================================
interface mem_readout_if #(
   parameter int AW = 10,
   parameter int DW = 8
);
   logic [AW-1:0] ram_addr;
   logic [DW-1:0] ram_dout;
   logic [DW-1:0] data_out;
   logic          data_valid;
   logic          data_ready;

   modport master (
      output ram_addr,
      input  ram_dout,
      output data_out,
      output data_valid,
      input  data_ready
   );

   modport slave (
      input  ram_addr,
      output ram_dout,
      input  data_out,
      input  data_valid,
      output data_ready
   );
endinterface
`default_nettype wire

// File: rtl/mem_readout.sv
`default_nettype none
// ============================================================================
// mem_readout : streams DEPTH bytes of a sync-read RAM out with a 16-bit sum
// Revision 1.0
// ============================================================================
module mem_readout #(
   parameter int DEPTH = 1024,
   parameter int AW    = 10,
   parameter int DW    = 8
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 start,
   mem_readout_if.master        bus,
   output logic [15:0]          checksum,
   output logic                 busy,
   output logic                 finished
);

   localparam logic [AW-1:0] C_LAST_IDX = AW'(DEPTH - 1);
   localparam logic [AW-1:0] C_ONE      = AW'(1);

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_ADDR = 3'd1,
      ST_WAIT = 3'd2,
      ST_SEND = 3'd3,
      ST_FIN  = 3'd4
   } state_t;

   state_t        r_state;
   state_t        w_next;
   logic [AW-1:0] r_index;
   logic [AW-1:0] r_addr;
   logic [DW-1:0] r_data;
   logic          r_valid;
   logic [15:0]   r_sum;
   logic          w_accept;
   logic          w_last;
   logic [AW-1:0] w_index_inc;

   assign w_last      = (r_index == C_LAST_IDX);
   assign w_index_inc = r_index + C_ONE;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next   = r_state;
      w_accept = 1'b0;
      busy     = 1'b0;
      finished = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (start) begin
               w_next = ST_ADDR;
            end
         end
         ST_ADDR: begin
            busy   = 1'b1;
            w_next = ST_WAIT;
         end
         ST_WAIT: begin
            busy   = 1'b1;
            w_next = ST_SEND;
         end
         ST_SEND: begin
            busy = 1'b1;
            if (bus.data_ready) begin
               w_accept = 1'b1;
               w_next   = w_last ? ST_FIN : ST_ADDR;
            end
         end
         ST_FIN: begin
            finished = 1'b1;
         end
         default: begin
            w_next = ST_IDLE;
         end
      endcase
   end

   // ADDR spends one cycle so the RAM can register the address before WAIT captures.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_index <= '0;
         r_addr  <= '0;
         r_data  <= '0;
         r_valid <= 1'b0;
         r_sum   <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (start) begin
                  r_index <= '0;
                  r_addr  <= '0;
                  r_sum   <= '0;
               end
            end
            ST_WAIT: begin
               r_data  <= bus.ram_dout;
               r_valid <= 1'b1;
            end
            ST_SEND: begin
               if (w_accept) begin
                  r_sum   <= r_sum + 16'(r_data);
                  r_valid <= 1'b0;
                  if (!w_last) begin
                     r_index <= w_index_inc;
                     r_addr  <= w_index_inc;
                  end
               end
            end
            default: begin
            end
         endcase
      end
   end

   assign bus.ram_addr   = r_addr;
   assign bus.data_out   = r_data;
   assign bus.data_valid = r_valid;
   assign checksum       = r_sum;

endmodule
`default_nettype wire

// File: tb/tb_mem_readout.sv
`default_nettype none
`timescale 1ns/1ps
// Randomized bench: sync-read RAM model plus in-order stream/sum reference.
module tb_mem_readout;

   localparam int DEPTH  = 1024;
   localparam int AW     = 10;
   localparam int DW     = 8;
   localparam int BUDGET = 20000;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [15:0] checksum;
   logic        busy;
   logic        finished;
   logic [7:0]  mem [DEPTH];
   int          n_checks = 0;
   int          n_pass   = 0;

   mem_readout_if #(.AW(AW), .DW(DW)) bus ();

   mem_readout #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
      .clk      (clk),
      .reset    (reset),
      .start    (start),
      .bus      (bus),
      .checksum (checksum),
      .busy     (busy),
      .finished (finished)
   );

   always #5 clk = ~clk;

   always @(posedge clk) bus.ram_dout <= mem[bus.ram_addr];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic check_zero(input string pfx);
      check({pfx, "_addr"},  32'(bus.ram_addr), 0);
      check({pfx, "_data"},  32'(bus.data_out), 0);
      check({pfx, "_valid"}, 32'(bus.data_valid), 0);
      check({pfx, "_sum"},   32'(checksum), 0);
      check({pfx, "_busy"},  32'(busy), 0);
      check({pfx, "_fin"},   32'(finished), 0);
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1;
      start = 1'b0;
      bus.data_ready = 1'b0;
      @(negedge clk);
      reset = 1'b0;
   endtask

   // mode 0: ready always high (cadence checked); mode 1: random ready.
   task automatic run(input int mode, input bit pulse, input int abort_at,
                      output logic [15:0] exp_sum);
      int          exp_idx = 0;
      int          cyc = 0;
      int          first_valid = -1;
      logic        pv = 1'b0;
      logic        pr = 1'b0;
      logic [7:0]  pd = '0;
      bit          done = 1'b0;
      bit          aborted = 1'b0;
      exp_sum = '0;
      @(negedge clk);
      start = 1'b1;
      bus.data_ready = (mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      pr = bus.data_ready;
      @(posedge clk);
      while (!done && cyc < BUDGET) begin
         #1;
         if (pulse && cyc == 0) start = 1'b0;
         cyc++;
         if (pv && pr) begin
            if (exp_idx < DEPTH) begin
               check("byte", 32'(pd), 32'(mem[exp_idx]));
               exp_sum = exp_sum + 16'(mem[exp_idx]);
            end else begin
               check("extra_handshake", exp_idx, DEPTH - 1);
            end
            exp_idx++;
         end
         if (pv && !pr) begin
            check("hold_valid", 32'(bus.data_valid), 1);
            check("hold_data", 32'(bus.data_out), 32'(pd));
         end
         if (mode == 0) check("cadence", 32'(bus.data_valid), 32'(cyc % 3 == 0));
         if (bus.data_valid && first_valid < 0) first_valid = cyc;
         if (abort_at > 0 && exp_idx == abort_at) begin
            #2 reset = 1'b1;
            #1 check_zero("abort");
            @(negedge clk);
            reset = 1'b0;
            start = 1'b0;
            aborted = 1'b1;
            done = 1'b1;
         end else begin
            done = finished;
            if (!done) check("busy_run", 32'(busy), 1);
            pv = bus.data_valid;
            pd = bus.data_out;
            if (mode != 0) bus.data_ready = 1'($urandom_range(0, 1));
            pr = bus.data_ready;
            if (!done) @(posedge clk);
         end
      end
      if (!aborted) begin
         check("finished", 32'(finished), 1);
         check("handshakes", exp_idx, DEPTH);
         check("checksum", 32'(checksum), 32'(exp_sum));
         if (mode == 0) check("first_valid", first_valid, 3);
      end
   endtask

   task automatic fin_check(input logic [15:0] exp_sum);
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         start = ~start;
         bus.data_ready = 1'($urandom_range(0, 1));
         @(posedge clk);
         #1;
         check("fin_hold", 32'(finished), 1);
         check("fin_busy", 32'(busy), 0);
         check("fin_valid", 32'(bus.data_valid), 0);
         check("fin_sum", 32'(checksum), 32'(exp_sum));
      end
      start = 1'b0;
   endtask

   initial begin
      logic [15:0] s;
      reset = 1'b1;
      start = 1'b0;
      bus.data_ready = 1'b0;
      for (int i = 0; i < DEPTH; i++) mem[i] = '0;
      repeat (3) @(posedge clk);
      #1 check_zero("reset");
      @(negedge clk);
      reset = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      check("idle_busy", 32'(busy), 0);
      check("idle_valid", 32'(bus.data_valid), 0);

      // Ramp pattern, start held
      for (int i = 0; i < DEPTH; i++) mem[i] = 8'(i);
      run(0, 1'b0, 0, s);
      check("sum_ramp", 32'(checksum), 32'h0000_FE00);
      fin_check(s);

      // All 0xFF, wrap of the running sum
      do_reset();
      for (int i = 0; i < DEPTH; i++) mem[i] = 8'hFF;
      run(0, 1'b0, 0, s);
      check("sum_ff", 32'(checksum), 32'h0000_FC00);

      // i*7+3 with random ready and a one-cycle start pulse
      do_reset();
      for (int i = 0; i < DEPTH; i++) mem[i] = 8'(i * 7 + 3);
      run(1, 1'b1, 0, s);
      fin_check(s);

      // Random data, asynchronous abort after 100 bytes, then full rerun
      do_reset();
      for (int i = 0; i < DEPTH; i++) mem[i] = 8'($urandom);
      run(1, 1'b0, 100, s);
      repeat (3) @(posedge clk);
      #1 check("post_abort_idle", 32'(busy), 0);
      run(0, 1'b0, 0, s);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
